// File: rtl/sw_handshake_driver_pkg.sv
// sw_handshake_driver_pkg: shared types and sizing helpers for the switch-input handshake driver
package sw_handshake_driver_pkg;
  typedef logic signed [7:0] byte_t;
  typedef enum logic [2:0] {IDLE, SETUP, HI, LO, WAIT} hs_state_t;
  function automatic int cnt_width(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = c > m ? c : m;
    return d > m ? d : m;
  endfunction
endpackage

// File: rtl/sw_handshake_driver_if.sv
// sw_handshake_driver_if: host-side byte stream, picomips switch/LED lines and status
interface sw_handshake_driver_if;
  import sw_handshake_driver_pkg::*;
  byte_t InData;
  logic  InValid;
  logic  InReady;
  byte_t SWData;
  logic  Handshake;
  byte_t LED;
  byte_t Result;
  logic  ResultValid;
  logic  Busy;
  modport master (output InData, InValid, LED, input InReady, SWData, Handshake, Result, ResultValid, Busy);
  modport slave  (input InData, InValid, LED, output InReady, SWData, Handshake, Result, ResultValid, Busy);
endinterface

// File: rtl/sw_handshake_driver_sync_byte_fifo.sv
// sync_byte_fifo: single-clock byte FIFO, registered pointers and count, no fall-through
module sync_byte_fifo import sw_handshake_driver_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  byte_t                      i_data,
  output byte_t                      o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  byte_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  // Storage write; contents need no reset since the count gates every read
  always_ff @(posedge i_clk)
    if (i_push) r_mem[r_wr] <= i_data;
  // Pointers wrap naturally at DEPTH; count nets push against pop
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      r_wr  <= i_push ? r_wr + AW'(1) : r_wr;
      r_rd  <= i_pop ? r_rd + AW'(1) : r_rd;
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  assign o_data  = r_mem[r_rd];
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
endmodule

// File: rtl/sw_handshake_driver.sv
// sw_handshake_driver: paces buffered host bytes onto SW[7:0] with a timed SW[8] pulse; SW_HANDSHAKE_DRIVER_RESULT_CAPTURE_EN adds LED capture
module sw_handshake_driver import sw_handshake_driver_pkg::*; #(
  parameter int DEPTH        = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int HI_CYCLES    = 8,
  parameter int LO_CYCLES    = 8,
  parameter int RESULT_WAIT  = 16
) (
  input logic                  Clock,
  input logic                  nReset,
  sw_handshake_driver_if.slave bus
);
  localparam int CW = cnt_width(max4(SETUP_CYCLES, HI_CYCLES, LO_CYCLES, RESULT_WAIT));
  typedef logic [CW-1:0] cnt_t;
  hs_state_t               r_state;
  cnt_t                    r_cnt;
  byte_t                   r_sw;
  logic                    r_hs;
  byte_t                   w_head;
  logic                    w_full;
  logic                    w_empty;
  logic [$clog2(DEPTH):0]  w_count;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_zero;
  assign w_push = bus.InValid & ~w_full;
  assign w_pop  = r_state == IDLE && !w_empty;
  assign w_zero = r_cnt == '0;
  sync_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (Clock),
    .i_rst_n (nReset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (bus.InData),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  // Phase sequencer: one shared down-counter reloaded on every phase change
  always_ff @(posedge Clock)
    if (!nReset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sw    <= '0;
      r_hs    <= 1'b0;
    end else begin
      r_cnt <= r_cnt - cnt_t'(1);
      case (r_state)
        IDLE:  if (w_pop) begin
          r_sw    <= w_head;
          r_cnt   <= cnt_t'(SETUP_CYCLES - 1);
          r_state <= SETUP;
        end
        SETUP: if (w_zero) begin
          r_hs    <= 1'b1;
          r_cnt   <= cnt_t'(HI_CYCLES - 1);
          r_state <= HI;
        end
        HI:    if (w_zero) begin
          r_hs    <= 1'b0;
          r_cnt   <= cnt_t'(LO_CYCLES - 1);
          r_state <= LO;
        end
`ifdef SW_HANDSHAKE_DRIVER_RESULT_CAPTURE_EN
        LO:    if (w_zero) begin
          r_cnt   <= cnt_t'(RESULT_WAIT - 1);
          r_state <= WAIT;
        end
        WAIT:  if (w_zero) r_state <= IDLE;
`else
        LO:    if (w_zero) r_state <= IDLE;
`endif
        default: r_state <= IDLE;
      endcase
    end
  assign bus.InReady   = ~w_full;
  assign bus.SWData    = r_sw;
  assign bus.Handshake = r_hs;
  assign bus.Busy      = r_state != IDLE || w_count != '0;
`ifdef SW_HANDSHAKE_DRIVER_RESULT_CAPTURE_EN
  byte_t r_res;
  logic  r_rv;
  // Sample LED as the settle wait expires and flag it for exactly one cycle
  always_ff @(posedge Clock)
    if (!nReset) begin
      r_res <= '0;
      r_rv  <= 1'b0;
    end else begin
      r_rv  <= r_state == WAIT && w_zero;
      r_res <= r_state == WAIT && w_zero ? bus.LED : r_res;
    end
  assign bus.Result      = r_res;
  assign bus.ResultValid = r_rv;
`else
  logic w_unused_led;
  assign w_unused_led    = ^bus.LED;
  assign bus.Result      = '0;
  assign bus.ResultValid = 1'b0;
`endif
endmodule

// File: tb/tb_sw_handshake_driver.sv
// tb_sw_handshake_driver: scoreboard bench for the switch-input handshake driver
module tb_sw_handshake_driver;
  import sw_handshake_driver_pkg::*;
  localparam int SETUP = 1;
  localparam int HI    = 8;
  localparam int LO    = 8;
  localparam int RW    = 16;
`ifdef SW_HANDSHAKE_DRIVER_RESULT_CAPTURE_EN
  localparam int PERIOD = 1 + SETUP + HI + LO + RW;
`else
  localparam int PERIOD = 1 + SETUP + HI + LO;
`endif
  localparam logic [7:0] LED_VAL = 8'hF3;

  logic Clock = 1'b0;
  logic nReset = 1'b0;
  always #5 Clock = ~Clock;

  sw_handshake_driver_if bif ();
  sw_handshake_driver #(
    .DEPTH(4), .SETUP_CYCLES(SETUP), .HI_CYCLES(HI), .LO_CYCLES(LO), .RESULT_WAIT(RW)
  ) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bif)
  );

  int n_pass = 0;
  int n_tot = 0;
  logic [7:0] q_exp[$];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor, sampled on the falling edge
  logic       hs_q = 1'b0;
  logic       rv_q = 1'b0;
  logic [7:0] hs_data = '0;
  int         cyc = 0;
  int         hi_len = 0;
  int         last_rise = 0;
  int         n_rise = 0;
  int         n_res = 0;
  logic       chk_period = 1'b0;
  int         per_base = 0;

  always @(negedge Clock) begin
    cyc++;
    if (nReset) begin
      if (bif.Handshake) begin
        if (!hs_q) begin
          if (q_exp.size() == 0) check("unexpected_hs", 8'd1, 8'd0);
          else check("swdata", bif.SWData, q_exp.pop_front());
          if (chk_period && n_rise > per_base) check("period", 8'(cyc - last_rise), 8'(PERIOD));
          hs_data = bif.SWData;
          hi_len = 0;
          last_rise = cyc;
          n_rise++;
        end else check("sw_stable", bif.SWData, hs_data);
        hi_len++;
      end else if (hs_q) check("hi_len", 8'(hi_len), 8'(HI));
      if (bif.ResultValid) begin
        check("result", bif.Result, LED_VAL);
        check("rv_width", {7'd0, rv_q}, 8'd0);
        n_res++;
      end
    end
    hs_q = nReset ? bif.Handshake : 1'b0;
    rv_q = nReset ? bif.ResultValid : 1'b0;
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bif.InData = d;
    bif.InValid = 1'b1;
    for (int i = 0; i < 200 && !bif.InReady; i++) tick();
    if (!bif.InReady) check("push_timeout", 8'd0, 8'd1);
    tick();
    q_exp.push_back(d);
    bif.InValid = 1'b0;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 400 && bif.Busy; i++) tick();
    check("idle_timeout", {7'd0, bif.Busy}, 8'd0);
  endtask

  int base;
  int exp_res = 0;

  initial begin
    bif.InData = 8'h55;
    bif.InValid = 1'b1;
    bif.LED = LED_VAL;
    // Reset held two edges with InValid high
    tick();
    tick();
    check("rst_inready", {7'd0, bif.InReady}, 8'd1);
    check("rst_hs", {7'd0, bif.Handshake}, 8'd0);
    check("rst_swdata", bif.SWData, 8'h00);
    check("rst_rv", {7'd0, bif.ResultValid}, 8'd0);
    check("rst_result", bif.Result, 8'h00);
    bif.InValid = 1'b0;
    nReset = 1'b1;
    tick();
    tick();
    check("rst_busy", {7'd0, bif.Busy}, 8'd0);
    check("rst_hs2", {7'd0, bif.Handshake}, 8'd0);

    // Single byte, cycle-exact timing
    push(8'h2A);
    exp_res++;
    check("t2_busy", {7'd0, bif.Busy}, 8'd1);
    check("t2_sw_k", bif.SWData, 8'h00);
    tick();
    check("t2_sw_k1", bif.SWData, 8'h2A);
    check("t2_hs_k1", {7'd0, bif.Handshake}, 8'd0);
    tick();
    check("t2_hs_k2", {7'd0, bif.Handshake}, 8'd1);
    repeat (HI - 1) tick();
    check("t2_hs_k9", {7'd0, bif.Handshake}, 8'd1);
    tick();
    check("t2_hs_k10", {7'd0, bif.Handshake}, 8'd0);
    repeat (LO - 1) tick();
    check("t2_busy_lo", {7'd0, bif.Busy}, 8'd1);
    tick();
`ifdef SW_HANDSHAKE_DRIVER_RESULT_CAPTURE_EN
    check("t2_busy_wait", {7'd0, bif.Busy}, 8'd1);
    repeat (RW - 1) tick();
    check("t2_rv_early", {7'd0, bif.ResultValid}, 8'd0);
    tick();
    check("t2_rv", {7'd0, bif.ResultValid}, 8'd1);
    check("t2_result", bif.Result, LED_VAL);
    tick();
    check("t2_rv_off", {7'd0, bif.ResultValid}, 8'd0);
`endif
    check("t2_idle", {7'd0, bif.Busy}, 8'd0);
    check("t2_sw_hold", bif.SWData, 8'h2A);

    // Five bytes into a 4-deep FIFO
    base = n_rise;
    per_base = n_rise;
    chk_period = 1'b1;
    for (int b = 1; b <= 5; b++) push(8'(b));
    exp_res += 5;
    check("t3_full_ready", {7'd0, bif.InReady}, 8'd0);
    bif.InData = 8'hEE;
    bif.InValid = 1'b1;
    repeat (3) tick();
    check("t3_full_hold", {7'd0, bif.InReady}, 8'd0);
    bif.InValid = 1'b0;
    wait_idle();
    check("t3_rises", 8'(n_rise - base), 8'd5);
    chk_period = 1'b0;

    // Push coinciding with pop at count 1
    base = n_rise;
    per_base = n_rise;
    chk_period = 1'b1;
    push(8'hA1);
    push(8'hB2);
    exp_res += 2;
    check("t4_sw", bif.SWData, 8'hA1);
    check("t4_busy", {7'd0, bif.Busy}, 8'd1);
    check("t4_ready", {7'd0, bif.InReady}, 8'd1);
    wait_idle();
    check("t4_rises", 8'(n_rise - base), 8'd2);
    chk_period = 1'b0;

    // Reset in the middle of the high phase
    base = n_rise;
    push(8'hC1);
    push(8'hD2);
    push(8'hE3);
    for (int i = 0; i < 50 && !bif.Handshake; i++) tick();
    check("t5_hs_seen", {7'd0, bif.Handshake}, 8'd1);
    repeat (3) tick();
    nReset = 1'b0;
    tick();
    q_exp.delete();
    check("t5_hs", {7'd0, bif.Handshake}, 8'd0);
    check("t5_sw", bif.SWData, 8'h00);
    check("t5_busy", {7'd0, bif.Busy}, 8'd0);
    check("t5_ready", {7'd0, bif.InReady}, 8'd1);
    nReset = 1'b1;
    repeat (3) tick();
    check("t5_busy2", {7'd0, bif.Busy}, 8'd0);
    check("t5_rises", 8'(n_rise - base), 8'd1);
    push(8'h77);
    exp_res++;
    wait_idle();
    check("t5_restart", 8'(n_rise - base), 8'd2);
    check("t5_sw_last", bif.SWData, 8'h77);

    check("q_empty", 8'(q_exp.size()), 8'd0);
`ifdef SW_HANDSHAKE_DRIVER_RESULT_CAPTURE_EN
    check("n_results", 8'(n_res), 8'(exp_res));
`else
    check("rv_never", 8'(n_res), 8'd0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
